store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered stores; SHALL be a power of two, at least 2.
REQ-002 Parameter ADDR_W, default 10: word address width, the same as the data-memory word index.
REQ-003 Parameter DATA_W, default 32: store data width.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 wr_en  in  1  core store strobe (the MemWrite condition).
REQ-007 wr_addr  in  ADDR_W  store word address.
REQ-008 wr_data  in  DATA_W  store data.
REQ-009 full  out  1  buffer holds DEPTH entries; the core stalls while this is high.
REQ-010 empty  out  1  buffer holds no entries.
REQ-011 count  out  $clog2(DEPTH)+1  number of valid entries.
REQ-012 ovf  out  1  sticky flag: a store was dropped.
REQ-013 rd_addr  in  ADDR_W  load word address, used for forwarding lookup.
REQ-014 rd_hit  out  1  rd_addr matches a buffered entry.
REQ-015 rd_data  out  DATA_W  forwarded data.
REQ-016 mem_req  out  1  drain request to the external data memory.
REQ-017 mem_addr  out  ADDR_W  head entry address.
REQ-018 mem_wdata  out  DATA_W  head entry data.
REQ-019 mem_ack  in  1  memory accepted the current request.

Function
REQ-020 The buffer SHALL be an in-order FIFO with head and tail pointers of width $clog2(DEPTH). Pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 Store accept rule:
- A store SHALL be accepted at the clock edge where wr_en=1 and full=0.
- The store SHALL be written at the tail, and the tail SHALL advance.
REQ-022 Store drop rule:
- wr_en=1 while full=1 SHALL drop the store, leave all entries unchanged, and set ovf=1.
- ovf SHALL stay set until reset.
REQ-023 full SHALL be (count==DEPTH) and empty SHALL be (count==0), both decoded combinationally from the registered count.
REQ-024 Drain FSM states:
- IDLE: mem_req=0.
- REQ: mem_req=1, with mem_addr/mem_wdata driven from the head entry.
REQ-025 Drain FSM transitions:
- IDLE->REQ on the edge after count becomes nonzero.
- REQ->REQ on mem_ack=1 when at least one entry remains after the pop.
- REQ->IDLE on mem_ack=1 when the pop empties the buffer.
- REQ->REQ (hold) on mem_ack=0.
REQ-026 While in REQ, mem_addr and mem_wdata SHALL stay stable until mem_ack=1.
REQ-027 mem_ack=1 in REQ SHALL pop the head at that edge. mem_ack while in IDLE SHALL be ignored.
REQ-028 Store latency: a store accepted at edge N into an empty buffer SHALL drive mem_req=1 from edge N+1.
REQ-029 Simultaneous accept and pop:
- count SHALL be unchanged.
- At count==1, the new entry SHALL become head and mem_req SHALL stay high.
REQ-030 When full=1, a pop SHALL NOT admit a same-cycle store. Acceptance depends only on the registered full flag.
REQ-031 mem_addr and mem_wdata SHALL read 0 in IDLE.

Reset
REQ-032 When rst is low, the block SHALL immediately force:
- pointers=0, count=0, ovf=0, FSM=IDLE;
- mem_req=0, full=0, empty=1, rd_hit=0.
REQ-033 Reset mid-drain SHALL discard all buffered entries without completing the handshake. Entry storage need not be cleared.
REQ-034 Release of rst SHALL take effect on the first rising clk edge after deassertion.

Configuration
REQ-035 Macro SWB_FORWARD_EN defined:
- rd_hit=1 when any valid entry, including a head being acked this cycle, has address == rd_addr.
- rd_data SHALL return the youngest matching entry; both outputs are combinational.
REQ-036 Macro SWB_FORWARD_EN undefined: rd_hit and rd_data SHALL be tied to 0, and no comparator logic SHALL be built.

Structure
REQ-037 Package swb_pkg SHALL hold:
- the drain FSM state type (IDLE, REQ);
- the default DEPTH, ADDR_W and DATA_W constants.
REQ-038 Entry storage and pointer logic SHALL be one sub-module, swb_fifo. The FSM, overflow flag and forwarding SHALL remain in store_write_buffer.

Verification
REQ-039 Reset test: hold rst=0 with random inputs. Expect mem_req=0, empty=1, count=0, ovf=0. Release rst, then one store (addr 5, data 0xAAAA_0001): expect mem_req=1 at the next edge with mem_addr=5.
REQ-040 Fill and overflow test (DEPTH=4, mem_ack=0):
- 5 stores: expect count=4 and full=1.
- 5th store dropped, ovf=1.
- mem_wdata still the first store's data.
REQ-041 Wait-state drain test: 3 stores, mem_ack asserted every 3rd cycle. Expect three in-order writes, addr/data stable during waits, FSM back to IDLE and empty=1 after the 3rd ack.
REQ-042 Same-edge store and ack test: count=1, wr_en=1 and mem_ack=1 on the same edge. Expect count=1, mem_req stays 1, mem_addr = new store address.
REQ-043 Forwarding test, SWB_FORWARD_EN defined:
- Stores addr 7=0x11, then addr 7=0x22, with rd_addr=7: expect rd_hit=1, rd_data=0x22.
- rd_addr=8: expect rd_hit=0.
- SWB_FORWARD_EN undefined: expect rd_hit=0 throughout.
REQ-044 Reset mid-drain test: assert rst while in REQ with count=3. Expect mem_req to drop immediately and count=0. After release, expect no request until a new store.

Source files
------------

// File: rtl/swb_pkg.sv
// Shared definitions for the store write buffer.
//   swb_state_e : drain FSM state encoding (IDLE, REQ)
//   SWB_DEPTH, SWB_ADDR_W, SWB_DATA_W : default parameter values
package swb_pkg;

  localparam int SWB_DEPTH  = 4;
  localparam int SWB_ADDR_W = 10;
  localparam int SWB_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } swb_state_e;

endpackage

// File: rtl/swb_fifo.sv
// Entry storage and head/tail/count bookkeeping for the store write buffer.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   push_i          : write push_addr_i/push_data_i at the tail (caller guarantees not full)
//   pop_i           : retire the head entry (caller guarantees not empty)
//   head_ptr_o      : index of the oldest entry
//   count_o         : number of valid entries
//   ent_addr_o/ent_data_o : raw storage, indexed by pointer
module swb_fifo
  import swb_pkg::*;
#(
  parameter int DEPTH  = SWB_DEPTH,
  parameter int ADDR_W = SWB_ADDR_W,
  parameter int DATA_W = SWB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic [PTR_W-1:0]  head_ptr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] ent_addr_o [DEPTH],
  output logic [DATA_W-1:0] ent_data_o [DEPTH]
);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
  always_comb begin
    head_d  = pop_i  ? head_q + 1'b1 : head_q;
    tail_d  = push_i ? tail_q + 1'b1 : tail_q;
    count_d = count_q + {{(CNT_W-1){1'b0}}, push_i} - {{(CNT_W-1){1'b0}}, pop_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; validity is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  assign head_ptr_o = head_q;
  assign count_o    = count_q;
  assign ent_addr_o = addr_q;
  assign ent_data_o = data_q;

endmodule

// File: rtl/store_write_buffer.sv
// In-order store write buffer between the core and the data memory.
// Stores are queued and drained one at a time through a req/ack handshake.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data  : core store; accepted when not full, dropped (ovf) when full
//   full, empty, count, ovf  : occupancy status, sticky overflow flag
//   rd_addr, rd_hit, rd_data : load forwarding lookup
//   mem_req, mem_addr, mem_wdata, mem_ack : drain handshake to data memory
// Build option: define SWB_FORWARD_EN to build the forwarding comparators;
// otherwise rd_hit/rd_data are tied to 0.
module store_write_buffer
  import swb_pkg::*;
#(
  parameter int DEPTH  = SWB_DEPTH,
  parameter int ADDR_W = SWB_ADDR_W,
  parameter int DATA_W = SWB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_hit,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  swb_state_e        state_q, state_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;
  logic [PTR_W-1:0]  head_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  swb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_addr_i (wr_addr),
    .push_data_i (wr_data),
    .head_ptr_o  (head_ptr),
    .count_o     (count_q),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Acceptance looks only at the registered full flag, so a pop in the same
  // cycle never frees a slot for a store that arrives while full.
  assign push = wr_en && !full;
  assign pop  = (state_q == REQ) && mem_ack;

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q || (wr_en && full);
    case (state_q)
      IDLE: if (count_q != '0) state_d = REQ;
      // Leave only when the last entry is popped with no store refilling it.
      REQ:  if (mem_ack && (count_q == CNT_W'(1)) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf       = ovf_q;
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = mem_req ? ent_addr[head_ptr] : '0;
  assign mem_wdata = mem_req ? ent_data[head_ptr] : '0;

`ifdef SWB_FORWARD_EN
  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (ent_addr[idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = ent_data[idx];
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_hit  = 1'b0;
  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4 defaults).
module tb_store_write_buffer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              full, empty, ovf;
  logic [2:0]        count;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  int checks;
  int failures;

  store_write_buffer #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ADDR_W'($urandom);
      wr_data = $urandom;
      mem_ack = 1'($urandom_range(0, 1));
      rd_addr = ADDR_W'($urandom);
      tick();
      checks++;
      if (mem_req !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || ovf !== 1'b0 ||
          full !== 1'b0 || rd_hit !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: req=%b empty=%b count=%0d ovf=%b full=%b hit=%b required 0 1 0 0 0 0",
                 mem_req, empty, count, ovf, full, rd_hit);
      end
    end
    idle_inputs();
    rd_addr = '0;
    rst = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hAAAA_0001;
    tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_store_accept: count=%0d req=%b required 1 0", count, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'd5 || mem_wdata !== 32'hAAAA_0001) begin
      failures++;
      $display("FAIL reset_first_store_req: req=%b addr=%0d data=%h required 1 5 aaaa0001",
               mem_req, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || empty !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_first_drain: req=%b empty=%b addr=%0d data=%h required 0 1 0 0",
               mem_req, empty, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(10 + i); wr_data = 32'h100 + i;
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL fill_status: count=%0d full=%b ovf=%b required 4 1 1", count, full, ovf);
    end
    checks++;
    if (mem_addr !== 10'd10 || mem_wdata !== 32'h100) begin
      failures++;
      $display("FAIL fill_head: addr=%0d data=%h required 10 00000100", mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== ADDR_W'(10 + i) || mem_wdata !== 32'h100 + i) begin
        failures++;
        $display("FAIL fill_drain_%0d: req=%b addr=%0d data=%h required 1 %0d %h",
                 i, mem_req, mem_addr, mem_wdata, 10 + i, 32'h100 + i);
      end
      tick();
    end
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || empty !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL fill_drained: req=%b empty=%b ovf=%b required 0 1 1", mem_req, empty, ovf);
    end
    do_reset();
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_cleared_by_reset: ovf=%b required 0", ovf);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(40 + i); wr_data = 32'h400 + i;
      tick();
    end
    wr_addr = 10'd99; wr_data = 32'h999;
    mem_ack = 1'b1;
    tick();
    wr_en = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if (count !== 3'd3 || ovf !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_no_admit: count=%0d ovf=%b full=%b required 3 1 0", count, ovf, full);
    end
    mem_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (mem_addr !== ADDR_W'(40 + i) || mem_wdata !== 32'h400 + i) begin
        failures++;
        $display("FAIL full_pop_drain_%0d: addr=%0d data=%h required %0d %h",
                 i, mem_addr, mem_wdata, 40 + i, 32'h400 + i);
      end
      tick();
    end
    mem_ack = 1'b0;
    checks++;
    if (empty !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_end: empty=%b req=%b required 1 0", empty, mem_req);
    end
    do_reset();
  endtask

  task automatic test_wait_drain();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(20 + i); wr_data = 32'hD0 + i;
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== ADDR_W'(20 + k) || mem_wdata !== 32'hD0 + k) begin
          failures++;
          $display("FAIL wait_hold_%0d_%0d: req=%b addr=%0d data=%h required 1 %0d %h",
                   k, w, mem_req, mem_addr, mem_wdata, 20 + k, 32'hD0 + k);
        end
        tick();
      end
      mem_ack = 1'b1;
      checks++;
      if (mem_addr !== ADDR_W'(20 + k) || mem_wdata !== 32'hD0 + k) begin
        failures++;
        $display("FAIL wait_ack_%0d: addr=%0d data=%h required %0d %h",
                 k, mem_addr, mem_wdata, 20 + k, 32'hD0 + k);
      end
      tick();
      mem_ack = 1'b0;
    end
    checks++;
    if (mem_req !== 1'b0 || empty !== 1'b1 || count !== 3'd0) begin
      failures++;
      $display("FAIL wait_end: req=%b empty=%b count=%0d required 0 1 0", mem_req, empty, count);
    end
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL idle_ack_ignored: req=%b count=%0d required 0 0", mem_req, count);
    end
  endtask

  task automatic test_same_edge();
    wr_en = 1'b1; wr_addr = 10'd30; wr_data = 32'h30;
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'd30 || count !== 3'd1) begin
      failures++;
      $display("FAIL same_edge_pre: req=%b addr=%0d count=%0d required 1 30 1", mem_req, mem_addr, count);
    end
    wr_en = 1'b1; wr_addr = 10'd31; wr_data = 32'h31;
    mem_ack = 1'b1;
    tick();
    wr_en = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if (count !== 3'd1 || mem_req !== 1'b1 || mem_addr !== 10'd31 || mem_wdata !== 32'h31) begin
      failures++;
      $display("FAIL same_edge_post: count=%0d req=%b addr=%0d data=%h required 1 1 31 00000031",
               count, mem_req, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (empty !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_drain: empty=%b req=%b required 1 0", empty, mem_req);
    end
  endtask

  task automatic test_forward_and_reset_mid_drain();
    logic       exp_hit;
    logic [31:0] exp_data;
`ifdef SWB_FORWARD_EN
    exp_hit  = 1'b1;
    exp_data = 32'h22;
`else
    exp_hit  = 1'b0;
    exp_data = 32'h0;
`endif
    rd_addr = 10'd7;
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 32'h11;
    tick();
    wr_addr = 10'd7; wr_data = 32'h22;
    tick();
    wr_addr = 10'd9; wr_data = 32'h99;
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_hit !== exp_hit || rd_data !== exp_data) begin
      failures++;
      $display("FAIL fwd_youngest: hit=%b data=%h required %b %h", rd_hit, rd_data, exp_hit, exp_data);
    end
    rd_addr = 10'd8;
    #1;
    checks++;
    if (rd_hit !== 1'b0) begin
      failures++;
      $display("FAIL fwd_miss: hit=%b required 0", rd_hit);
    end
    checks++;
    if (count !== 3'd3 || mem_req !== 1'b1 || mem_addr !== 10'd7) begin
      failures++;
      $display("FAIL mid_drain_pre: count=%0d req=%b addr=%0d required 3 1 7", count, mem_req, mem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL mid_drain_reset: req=%b count=%0d empty=%b required 0 0 1", mem_req, count, empty);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_req !== 1'b0 || count !== 3'd0) begin
        failures++;
        $display("FAIL mid_drain_quiet_%0d: req=%b count=%0d required 0 0", i, mem_req, count);
      end
    end
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'h33;
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'd3 || mem_wdata !== 32'h33) begin
      failures++;
      $display("FAIL mid_drain_new_store: req=%b addr=%0d data=%h required 1 3 00000033",
               mem_req, mem_addr, mem_wdata);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rd_addr  = '0;
    idle_inputs();
    test_reset();
    test_fill_overflow();
    test_full_pop();
    test_wait_drain();
    test_same_edge();
    test_forward_and_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
